// File: rtl/ycr1_req_mux_if.sv
// Request/response bundle shared by the core ports and the memory port of ycr1_req_mux.
`timescale 1ns/1ps
interface ycr1_req_mux_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  logic          req;
  logic          req_ack;
  logic          cmd;
  logic [1:0]    width;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [1:0]    resp;
  logic [DW-1:0] rdata;

  // Issuer of commands / consumer of responses
  modport master (
    output req, cmd, width, addr, wdata,
    input  req_ack, resp, rdata
  );

  modport slave (
    input  req, cmd, width, addr, wdata,
    output req_ack, resp, rdata
  );
endinterface

// File: rtl/ycr1_req_mux.sv
// ycr1_req_mux: routes the arbiter-granted core port onto the shared memory port and returns
// in-order responses to their issuer. Optional response timeout: YCR1_REQ_MUX_TIMEOUT_EN.
`timescale 1ns/1ps
module ycr1_req_mux #(
  parameter int unsigned AW     = 32,
  parameter int unsigned DW     = 32,
  parameter int unsigned OUTSTD = 2,
  parameter int unsigned TMO_W  = 8
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [1:0]    gnt,
  output logic          arb_ack,
  ycr1_req_mux_if.slave  p0,
  ycr1_req_mux_if.slave  p1,
  ycr1_req_mux_if.master m,
  output logic          err_spur
);

  localparam int unsigned PW = $clog2(OUTSTD);
  localparam int unsigned CW = $clog2(OUTSTD + 1);

  if (OUTSTD < 2 || (OUTSTD & (OUTSTD - 1)) != 0 || TMO_W < 1) begin : g_param_chk
    $error("ycr1_req_mux: OUTSTD must be a power of 2 >= 2 and TMO_W >= 1");
  end

  logic          sel0;
  logic          sel1;
  logic          full;
  logic          empty;
  logic          accept;
  logic          resp_vld;
  logic          pop;
  logic          tmo_fire;
  logic          head;
  logic [1:0]    rsp_code;
  logic [DW-1:0] rsp_data;

  logic [OUTSTD-1:0] id_mem;
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     count;

  assign sel0     = (gnt == 2'b00);
  assign sel1     = (gnt == 2'b01);
  assign full     = (count == CW'(OUTSTD));
  assign empty    = (count == CW'(0));
  assign resp_vld = (m.resp != 2'b00);
  assign head     = id_mem[rd_ptr];

  // Zero-latency command mux; a full ID FIFO holds the request back
  always_comb begin
    m.req   = 1'b0;
    m.cmd   = 1'b0;
    m.width = 2'b00;
    m.addr  = AW'(0);
    m.wdata = DW'(0);
    if (sel0) begin
      m.req   = p0.req & ~full;
      m.cmd   = p0.cmd;
      m.width = p0.width;
      m.addr  = p0.addr;
      m.wdata = p0.wdata;
    end else if (sel1) begin
      m.req   = p1.req & ~full;
      m.cmd   = p1.cmd;
      m.width = p1.width;
      m.addr  = p1.addr;
      m.wdata = p1.wdata;
    end
  end

  assign accept     = m.req & m.req_ack;
  assign arb_ack    = accept;
  assign p0.req_ack = accept & sel0;
  assign p1.req_ack = accept & sel1;

  assign pop      = ~empty & (resp_vld | tmo_fire);
  assign rsp_code = tmo_fire ? 2'b10 : m.resp;
  assign rsp_data = tmo_fire ? DW'(0) : m.rdata;

  // Response demux: only the port at the head of the ID FIFO sees the response
  always_comb begin
    p0.resp  = 2'b00;
    p0.rdata = DW'(0);
    p1.resp  = 2'b00;
    p1.rdata = DW'(0);
    if (!empty) begin
      if (head) begin
        p1.resp  = rsp_code;
        p1.rdata = rsp_data;
      end else begin
        p0.resp  = rsp_code;
        p0.rdata = rsp_data;
      end
    end
  end

  // Port-id FIFO and sticky spurious-response flag
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      id_mem   <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      err_spur <= 1'b0;
    end else begin
      if (accept) begin
        id_mem[wr_ptr] <= sel1;
        wr_ptr         <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (accept && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !accept) begin
        count <= count - CW'(1);
      end
      if (resp_vld && empty) begin
        err_spur <= 1'b1;
      end
    end
  end

`ifdef YCR1_REQ_MUX_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_cnt;

  // A real response in the same cycle wins over an expiring timeout
  assign tmo_fire = ~empty & ~resp_vld & (tmo_cnt == {TMO_W{1'b1}});

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tmo_cnt <= '0;
    end else if (pop || empty) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + TMO_W'(1);
    end
  end
`else
  assign tmo_fire = 1'b0;
`endif

endmodule

// File: tb/tb_ycr1_req_mux.sv
// Self-checking bench for ycr1_req_mux: directed vector table, hand sequences, random vs. queue model.
`timescale 1ns/1ps
module tb_ycr1_req_mux;
  localparam int unsigned AW     = 32;
  localparam int unsigned DW     = 32;
  localparam int unsigned OUTSTD = 2;
  localparam int unsigned TMO_W  = 4;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [1:0] gnt;
  logic       arb_ack;
  logic       err_spur;

  ycr1_req_mux_if #(.AW(AW), .DW(DW)) p0_if ();
  ycr1_req_mux_if #(.AW(AW), .DW(DW)) p1_if ();
  ycr1_req_mux_if #(.AW(AW), .DW(DW)) m_if ();

  ycr1_req_mux #(.AW(AW), .DW(DW), .OUTSTD(OUTSTD), .TMO_W(TMO_W)) dut (
    .clk(clk), .rstn(rstn), .gnt(gnt), .arb_ack(arb_ack),
    .p0(p0_if), .p1(p1_if), .m(m_if), .err_spur(err_spur)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  gnt;
    logic        r0, c0; logic [1:0] w0; logic [31:0] a0, d0;
    logic        r1, c1; logic [1:0] w1; logic [31:0] a1, d1;
    logic        ack;
    logic [1:0]  resp;
    logic [31:0] rdata;
  } in_t;

  typedef struct {
    in_t         in;
    logic        mreq, aack, ack0, ack1;
    logic [31:0] maddr;
    logic [1:0]  rs0; logic [31:0] rd0;
    logic [1:0]  rs1; logic [31:0] rd1;
    logic        err;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  in_t  cur;
  int   q[$];
  bit   m_err;
  int   tmo;
  vec_t tbl[14];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic in_t mk(input logic [1:0] g, input logic r0, input logic [31:0] a0,
                             input logic r1, input logic [31:0] a1, input logic ack,
                             input logic [1:0] rs, input logic [31:0] rd);
    in_t v;
    v.gnt = g;
    v.r0 = r0; v.c0 = 1'b0; v.w0 = 2'b10; v.a0 = a0; v.d0 = ~a0;
    v.r1 = r1; v.c1 = 1'b1; v.w1 = 2'b01; v.a1 = a1; v.d1 = a1 ^ 32'h5555_5555;
    v.ack = ack; v.resp = rs; v.rdata = rd;
    return v;
  endfunction

  function automatic in_t idle();
    return mk(2'b11, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 2'b00, 32'h0);
  endfunction

  function automatic vec_t ex(input in_t i, input logic mreq, input logic aack, input logic ack0,
                              input logic ack1, input logic [31:0] maddr, input logic [1:0] rs0,
                              input logic [31:0] rd0, input logic [1:0] rs1, input logic [31:0] rd1,
                              input logic err);
    vec_t v;
    v.in = i; v.mreq = mreq; v.aack = aack; v.ack0 = ack0; v.ack1 = ack1; v.maddr = maddr;
    v.rs0 = rs0; v.rd0 = rd0; v.rs1 = rs1; v.rd1 = rd1; v.err = err;
    return v;
  endfunction

  task automatic drive(input in_t v);
    cur = v;
    gnt = v.gnt;
    p0_if.req = v.r0; p0_if.cmd = v.c0; p0_if.width = v.w0; p0_if.addr = v.a0; p0_if.wdata = v.d0;
    p1_if.req = v.r1; p1_if.cmd = v.c1; p1_if.width = v.w1; p1_if.addr = v.a1; p1_if.wdata = v.d1;
    m_if.req_ack = v.ack; m_if.resp = v.resp; m_if.rdata = v.rdata;
  endtask

  function automatic bit exp_sel_req();
    if (cur.gnt == 2'b00) return cur.r0;
    if (cur.gnt == 2'b01) return cur.r1;
    return 1'b0;
  endfunction

  function automatic bit exp_fire();
    bit f;
    f = 1'b0;
`ifdef YCR1_REQ_MUX_TIMEOUT_EN
    f = (q.size() > 0) && (cur.resp == 2'b00) && (tmo == (1 << TMO_W) - 1);
`endif
    return f;
  endfunction

  // Reference: queue of issuing port ids; head of queue owns the current response
  task automatic model_check();
    bit          s0, s1, mreq, acc, fire;
    logic        ec;
    logic [1:0]  ew;
    logic [31:0] ea, ed;
    logic [1:0]  rs[2];
    logic [31:0] rd[2];
    s0   = (cur.gnt == 2'b00);
    s1   = (cur.gnt == 2'b01);
    mreq = exp_sel_req() && (q.size() < OUTSTD);
    acc  = mreq && cur.ack;
    fire = exp_fire();
    ec = s0 ? cur.c0 : s1 ? cur.c1 : 1'b0;
    ew = s0 ? cur.w0 : s1 ? cur.w1 : 2'b00;
    ea = s0 ? cur.a0 : s1 ? cur.a1 : 32'h0;
    ed = s0 ? cur.d0 : s1 ? cur.d1 : 32'h0;
    rs[0] = 2'b00; rs[1] = 2'b00; rd[0] = 32'h0; rd[1] = 32'h0;
    if (q.size() > 0) begin
      rs[q[0]] = fire ? 2'b10 : cur.resp;
      rd[q[0]] = fire ? 32'h0 : cur.rdata;
    end
    chk("m_req",    64'(m_if.req),      64'(mreq));
    chk("m_cmd",    64'(m_if.cmd),      64'(ec));
    chk("m_width",  64'(m_if.width),    64'(ew));
    chk("m_addr",   64'(m_if.addr),     64'(ea));
    chk("m_wdata",  64'(m_if.wdata),    64'(ed));
    chk("arb_ack",  64'(arb_ack),       64'(acc));
    chk("p0_ack",   64'(p0_if.req_ack), 64'(acc && s0));
    chk("p1_ack",   64'(p1_if.req_ack), 64'(acc && s1));
    chk("p0_resp",  64'(p0_if.resp),    64'(rs[0]));
    chk("p0_rdata", 64'(p0_if.rdata),   64'(rd[0]));
    chk("p1_resp",  64'(p1_if.resp),    64'(rs[1]));
    chk("p1_rdata", 64'(p1_if.rdata),   64'(rd[1]));
    chk("err_spur", 64'(err_spur),      64'(m_err));
  endtask

  task automatic model_update();
    bit acc, fire, s1;
    s1   = (cur.gnt == 2'b01);
    acc  = exp_sel_req() && (q.size() < OUTSTD) && cur.ack;
    fire = exp_fire();
    if (q.size() == 0) begin
      if (cur.resp != 2'b00) m_err = 1'b1;
      tmo = 0;
    end else if (cur.resp != 2'b00 || fire) begin
      void'(q.pop_front());
      tmo = 0;
    end else begin
      tmo++;
    end
    if (acc) q.push_back(int'(s1));
  endtask

  task automatic tick();
    @(posedge clk);
    if (rstn) model_update();
    #1;
  endtask

  task automatic run(input in_t v);
    drive(v);
    #1;
    model_check();
    tick();
  endtask

  task automatic do_reset();
    drive(idle());
    rstn = 1'b0;
    q.delete(); m_err = 1'b0; tmo = 0;
    #1;
    chk("rst m_req",    64'(m_if.req),   64'(0));
    chk("rst p0_resp",  64'(p0_if.resp), 64'(0));
    chk("rst p1_resp",  64'(p1_if.resp), 64'(0));
    chk("rst err_spur", 64'(err_spur),   64'(0));
    model_check();
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  initial begin
    in_t v;
    tbl[0]  = ex(mk(2'b00, 1'b1, 32'h100, 1'b0, 32'h0, 1'b1, 2'b00, 32'h0),
                 1'b1, 1'b1, 1'b1, 1'b0, 32'h100, 2'b00, 32'h0, 2'b00, 32'h0, 1'b0);
    tbl[1]  = ex(idle(), 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 2'b00, 32'h0, 2'b00, 32'h0, 1'b0);
    tbl[2]  = ex(mk(2'b11, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 2'b01, 32'hA5A5_A5A5),
                 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 2'b01, 32'hA5A5_A5A5, 2'b00, 32'h0, 1'b0);
    tbl[3]  = ex(mk(2'b00, 1'b1, 32'h200, 1'b0, 32'h0, 1'b1, 2'b00, 32'h0),
                 1'b1, 1'b1, 1'b1, 1'b0, 32'h200, 2'b00, 32'h0, 2'b00, 32'h0, 1'b0);
    tbl[4]  = ex(mk(2'b01, 1'b0, 32'h0, 1'b1, 32'h300, 1'b1, 2'b00, 32'h0),
                 1'b1, 1'b1, 1'b0, 1'b1, 32'h300, 2'b00, 32'h0, 2'b00, 32'h0, 1'b0);
    tbl[5]  = ex(mk(2'b00, 1'b1, 32'h400, 1'b0, 32'h0, 1'b1, 2'b00, 32'h0),
                 1'b0, 1'b0, 1'b0, 1'b0, 32'h400, 2'b00, 32'h0, 2'b00, 32'h0, 1'b0);
    tbl[6]  = ex(mk(2'b00, 1'b1, 32'h400, 1'b0, 32'h0, 1'b1, 2'b01, 32'h11),
                 1'b0, 1'b0, 1'b0, 1'b0, 32'h400, 2'b01, 32'h11, 2'b00, 32'h0, 1'b0);
    tbl[7]  = ex(mk(2'b00, 1'b1, 32'h400, 1'b0, 32'h0, 1'b1, 2'b01, 32'h22),
                 1'b1, 1'b1, 1'b1, 1'b0, 32'h400, 2'b00, 32'h0, 2'b01, 32'h22, 1'b0);
    tbl[8]  = ex(mk(2'b11, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 2'b10, 32'h0),
                 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 2'b10, 32'h0, 2'b00, 32'h0, 1'b0);
    tbl[9]  = ex(mk(2'b11, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 2'b01, 32'h33),
                 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 2'b00, 32'h0, 2'b00, 32'h0, 1'b0);
    tbl[10] = ex(idle(), 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 2'b00, 32'h0, 2'b00, 32'h0, 1'b1);
    tbl[11] = ex(mk(2'b10, 1'b1, 32'h500, 1'b1, 32'h600, 1'b1, 2'b00, 32'h0),
                 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 2'b00, 32'h0, 2'b00, 32'h0, 1'b1);
    tbl[12] = ex(mk(2'b01, 1'b1, 32'h500, 1'b1, 32'h600, 1'b1, 2'b00, 32'h0),
                 1'b1, 1'b1, 1'b0, 1'b1, 32'h600, 2'b00, 32'h0, 2'b00, 32'h0, 1'b1);
    tbl[13] = ex(mk(2'b11, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 2'b01, 32'h44),
                 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 2'b00, 32'h0, 2'b01, 32'h44, 1'b1);

    do_reset();

    foreach (tbl[i]) begin
      drive(tbl[i].in);
      #1;
      chk($sformatf("row%0d m_req", i),    64'(m_if.req),      64'(tbl[i].mreq));
      chk($sformatf("row%0d arb_ack", i),  64'(arb_ack),       64'(tbl[i].aack));
      chk($sformatf("row%0d p0_ack", i),   64'(p0_if.req_ack), 64'(tbl[i].ack0));
      chk($sformatf("row%0d p1_ack", i),   64'(p1_if.req_ack), 64'(tbl[i].ack1));
      chk($sformatf("row%0d m_addr", i),   64'(m_if.addr),     64'(tbl[i].maddr));
      chk($sformatf("row%0d p0_resp", i),  64'(p0_if.resp),    64'(tbl[i].rs0));
      chk($sformatf("row%0d p0_rdata", i), 64'(p0_if.rdata),   64'(tbl[i].rd0));
      chk($sformatf("row%0d p1_resp", i),  64'(p1_if.resp),    64'(tbl[i].rs1));
      chk($sformatf("row%0d p1_rdata", i), 64'(p1_if.rdata),   64'(tbl[i].rd1));
      chk($sformatf("row%0d err_spur", i), 64'(err_spur),      64'(tbl[i].err));
      model_check();
      tick();
    end

    // Sticky error is cleared only by reset
    do_reset();
    chk("err cleared", 64'(err_spur), 64'(0));

    // Reset with a command in flight discards it; the late response is spurious
    run(mk(2'b01, 1'b0, 32'h0, 1'b1, 32'h800, 1'b1, 2'b00, 32'h0));
    do_reset();
    drive(mk(2'b11, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 2'b01, 32'h66));
    #1;
    chk("late p1_resp", 64'(p1_if.resp), 64'(0));
    chk("late p0_resp", 64'(p0_if.resp), 64'(0));
    model_check();
    tick();
    drive(idle());
    #1;
    chk("late err_spur", 64'(err_spur), 64'(1));
    model_check();
    tick();

`ifdef YCR1_REQ_MUX_TIMEOUT_EN
    do_reset();
    run(mk(2'b00, 1'b1, 32'h700, 1'b0, 32'h0, 1'b1, 2'b00, 32'h0));
    for (int k = 0; k < 15; k++) begin
      drive(idle());
      #1;
      chk("tmo wait p0_resp", 64'(p0_if.resp), 64'(0));
      model_check();
      tick();
    end
    drive(idle());
    #1;
    chk("tmo p0_resp", 64'(p0_if.resp), 64'(2'b10));
    model_check();
    tick();
    run(mk(2'b11, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 2'b01, 32'h55));
    drive(idle());
    #1;
    chk("tmo late err_spur", 64'(err_spur), 64'(1));
    tick();
`endif

    do_reset();
    for (int n = 0; n < 3000; n++) begin
      v.gnt   = 2'($urandom_range(0, 3));
      v.r0    = 1'($urandom_range(0, 1));
      v.c0    = 1'($urandom_range(0, 1));
      v.w0    = 2'($urandom_range(0, 2));
      v.a0    = $urandom;
      v.d0    = $urandom;
      v.r1    = 1'($urandom_range(0, 1));
      v.c1    = 1'($urandom_range(0, 1));
      v.w1    = 2'($urandom_range(0, 2));
      v.a1    = $urandom;
      v.d1    = $urandom;
      v.ack   = ($urandom_range(0, 3) != 0);
      v.resp  = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 2)) : 2'b00;
      v.rdata = $urandom;
      run(v);
      if (n == 1500) do_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
